instruction_fetch_decode: RTL and testbench
===========================================

# instruction_fetch_decode

Fetch/decode front end of the 8-bit core. Fetches one 8-bit instruction per request from instruction memory over a req/valid handshake, maintains the program counter, and splits the instruction into opcode, register field and 2-bit immediate. The immediate output feeds `sign_extension` directly; opcode and register field go to the register file and ALU control. Handles branch redirect, downstream stall and a HALT opcode.

## Interface
- `PC_WIDTH`, 8, program-counter and instruction-address width
- `INSTR_WIDTH`, 8, instruction width (fixed format below; only 8 is supported)
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request; held high until `imem_valid`
- `imem_addr`  out  PC_WIDTH  fetch address, equals PC while `imem_req` high
- `imem_rdata`  in  INSTR_WIDTH  instruction data, sampled when `imem_valid`
- `imem_valid`  in  1  memory response strobe, any latency ≥1 cycle after request
- `stall`  in  1  downstream not ready; freezes decode outputs
- `branch_taken`  in  1  redirect request from execute
- `branch_target`  in  PC_WIDTH  redirect address
- `decode_valid`  out  1  decode outputs hold a live instruction
- `opcode`  out  4  instruction[7:4]
- `reg_field`  out  2  instruction[3:2]
- `immediate`  out  2  instruction[1:0], raw, to `sign_extension`
- `pc_out`  out  PC_WIDTH  address of the instruction on the decode outputs
- `halted`  out  1  HALT instruction decoded; core frozen

## Operation
- States: FETCH, ISSUE, HALT.
- Reset: state=FETCH, PC=0, `decode_valid`=0, `opcode`/`reg_field`/`immediate`/`pc_out`=0, `halted`=0, `imem_req`=0. `imem_req` rises on the first edge after reset deasserts.
- FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_valid`: register fields into outputs, `pc_out`<=PC, PC<=PC+1 (mod 2^PC_WIDTH, 8'hFF wraps to 8'h00), `decode_valid`<=1, `imem_req`<=0, go ISSUE. If opcode is 4'hF (HALT), go HALT instead.
- ISSUE: if `stall`, hold all outputs and stay. Otherwise `decode_valid`<=0, go FETCH. Each instruction is valid for at least one cycle.
- HALT: `decode_valid`=1 with the HALT instruction held, `halted`=1, `imem_req`=0. Left only through `reset`; `branch_taken` is ignored.
- Branch (FETCH or ISSUE): `branch_taken` has priority over `imem_valid` and `stall`. PC<=`branch_target`, `decode_valid`<=0, go FETCH.
  - A response arriving in the same cycle is discarded.
  - A response still outstanding from an aborted request is discarded: one `pending_kill` flag drops the next `imem_valid` after a mid-FETCH redirect.
- `imem_valid` outside FETCH is ignored, except when it consumes `pending_kill`.
- Reset mid-operation: asynchronous return to reset values; any in-flight response is ignored because `imem_req`=0 and state=FETCH with no request outstanding.

## Timing
- Fetch-to-decode latency: decode outputs update on the edge that samples `imem_valid`.
- `sign_extension` registers again, so `sign_extended` is valid one cycle after `decode_valid` rises.
- Minimum throughput: one instruction per 3 cycles with 1-cycle memory (request, response, issue).
- Branch: redirect takes effect on the sampling edge. The next `imem_addr`=`branch_target` in the following cycle.
- `stall` is sampled every edge in ISSUE. Release advances on the same edge.

## Structure
- Shared package `core_pkg`:
  - opcode constants, including `OP_HALT`=4'hF
  - field bit positions (`OPC_HI`=7, `OPC_LO`=4, `REG_HI`=3, `REG_LO`=2, `IMM_HI`=1, `IMM_LO`=0)
  - state encoding FETCH/ISSUE/HALT
- One natural sub-module `pc_reg`: PC register with reset, increment and load.
- Decode field split stays inline.

## Test plan
- Reset then memory returning 8'h3A after 1 cycle: `imem_addr`=0; `opcode`=3, `reg_field`=2, `immediate`=2'b10, `pc_out`=0; `decode_valid` high 1 cycle; next `imem_addr`=1.
- Immediate path: instruction 8'h13 → `immediate`=2'b11 → `sign_extended`=8'hFF one cycle later. Instruction 8'h11 → 8'h01.
- `stall` held 3 cycles during ISSUE → outputs and `decode_valid` constant for 4 cycles; no new `imem_req` until release.
- `branch_taken` with target 8'h40 while a fetch of address 5 is outstanding (response 2 cycles later):
  - the late response is dropped;
  - next request has `imem_addr`=8'h40;
  - `pc_out`=8'h40 on the next decode.
- PC at 8'hFF fetches → next `imem_addr`=8'h00. HALT 8'hF0 → `halted`=1, `imem_req` stays 0, `branch_taken` ignored.
- `reset` asserted mid-FETCH with response pending → all outputs 0 immediately; stale `imem_valid` after release does not set `decode_valid`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: opcodes, instruction field positions, front-end states.
package core_pkg;

  // Opcode constants (instruction[7:4])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions
  localparam int unsigned OPC_HI = 7;
  localparam int unsigned OPC_LO = 4;
  localparam int unsigned REG_HI = 3;
  localparam int unsigned REG_LO = 2;
  localparam int unsigned IMM_HI = 1;
  localparam int unsigned IMM_LO = 0;

  // Fetch/decode front-end states
  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StIssue = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: asynchronous reset to 0, load has priority over increment, wraps modulo 2^PC_WIDTH.
module pc_reg #(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_value,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_q;

  // PC update: redirect load beats sequential increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else if (load) begin
      pc_q <= load_value;
    end else if (inc) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode front end: req/valid instruction fetch, PC maintenance, field split, branch, stall, HALT.
module instruction_fetch_decode
  import core_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   decode_valid,
  output logic [3:0]             opcode,
  output logic [1:0]             reg_field,
  output logic [1:0]             immediate,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   halted
);

  fetch_state_e        state_q, state_d;
  logic                req_q, req_d;
  logic                kill_q, kill_d;
  logic                dvalid_q, dvalid_d;
  logic [3:0]          opcode_q;
  logic [1:0]          reg_q, imm_q;
  logic [PC_WIDTH-1:0] pc_out_q;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_load, pc_inc, capture, valid_live;

  pc_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (pc_load),
    .load_value (branch_target),
    .inc        (pc_inc),
    .pc         (pc)
  );

  // A response matching an aborted request is swallowed by kill_q before anything else sees it
  assign valid_live = imem_valid && !kill_q;

  // Next-state logic: branch first, then response acceptance / stall handling
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    kill_d   = kill_q;
    dvalid_d = dvalid_q;
    capture  = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    if (imem_valid && kill_q) begin
      kill_d = 1'b0;
    end
    unique case (state_q)
      StFetch: begin
        if (branch_taken) begin
          pc_load  = 1'b1;
          dvalid_d = 1'b0;
          req_d    = 1'b1;
          // Current request still in flight (not answered this cycle) must be dropped later
          kill_d   = (req_q && !valid_live) || (kill_q && !imem_valid);
        end else if (valid_live && req_q) begin
          capture  = 1'b1;
          pc_inc   = 1'b1;
          dvalid_d = 1'b1;
          req_d    = 1'b0;
          state_d  = (imem_rdata[OPC_HI:OPC_LO] == OP_HALT) ? StHalt : StIssue;
        end else begin
          req_d = 1'b1;
        end
      end
      StIssue: begin
        if (branch_taken) begin
          pc_load  = 1'b1;
          dvalid_d = 1'b0;
          req_d    = 1'b1;
          state_d  = StFetch;
        end else if (!stall) begin
          dvalid_d = 1'b0;
          req_d    = 1'b1;
          state_d  = StFetch;
        end
      end
      StHalt: begin
        req_d = 1'b0;
      end
      default: begin
        state_d  = StFetch;
        req_d    = 1'b0;
        dvalid_d = 1'b0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      req_q    <= 1'b0;
      kill_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      kill_q   <= kill_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Decode field registers, loaded on the edge that accepts a response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q <= '0;
      reg_q    <= '0;
      imm_q    <= '0;
      pc_out_q <= '0;
    end else if (capture) begin
      opcode_q <= imem_rdata[OPC_HI:OPC_LO];
      reg_q    <= imem_rdata[REG_HI:REG_LO];
      imm_q    <= imem_rdata[IMM_HI:IMM_LO];
      pc_out_q <= pc;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc;
  assign decode_valid = dvalid_q;
  assign opcode       = opcode_q;
  assign reg_field    = reg_q;
  assign immediate    = imm_q;
  assign pc_out       = pc_out_q;
  assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Directed self-checking bench for instruction_fetch_decode.
module tb_instruction_fetch_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       decode_valid;
  logic [3:0] opcode;
  logic [1:0] reg_field;
  logic [1:0] immediate;
  logic [7:0] pc_out;
  logic       halted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch_decode #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .decode_valid  (decode_valid),
    .opcode        (opcode),
    .reg_field     (reg_field),
    .immediate     (immediate),
    .pc_out        (pc_out),
    .halted        (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory answers after lat idle cycles; returns just after the sampling edge
  task automatic mem_resp(input logic [7:0] d, input int lat);
    for (int i = 0; i < lat; i++) step();
    imem_valid = 1'b1;
    imem_rdata = d;
    step();
    imem_valid = 1'b0;
    imem_rdata = 8'h00;
  endtask

  task automatic check_decode(input string tag, input logic [3:0] op, input logic [1:0] rf,
                              input logic [1:0] im, input logic [7:0] pc);
    check({tag, ".valid"}, 32'(decode_valid), 32'd1);
    check({tag, ".opcode"}, 32'(opcode), 32'(op));
    check({tag, ".reg"}, 32'(reg_field), 32'(rf));
    check({tag, ".imm"}, 32'(immediate), 32'(im));
    check({tag, ".pc_out"}, 32'(pc_out), 32'(pc));
  endtask

  initial begin
    reset = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 8'h00;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    step();
    step();
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.addr", 32'(imem_addr), 32'd0);
    check("rst.dvalid", 32'(decode_valid), 32'd0);
    check("rst.opcode", 32'(opcode), 32'd0);
    check("rst.pc_out", 32'(pc_out), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);

    // First edge after release raises the request at address 0
    reset = 1'b0;
    step();
    check("first.req", 32'(imem_req), 32'd1);
    check("first.addr", 32'(imem_addr), 32'd0);

    // 8'h3A: opcode 3, reg 2, imm 2, one cycle of decode_valid
    mem_resp(8'h3A, 1);
    check_decode("i3a", 4'h3, 2'd2, 2'd2, 8'h00);
    check("i3a.req", 32'(imem_req), 32'd0);
    step();
    check("i3a.dvalid_drop", 32'(decode_valid), 32'd0);
    check("i3a.next_req", 32'(imem_req), 32'd1);
    check("i3a.next_addr", 32'(imem_addr), 32'd1);

    // Immediate path
    mem_resp(8'h13, 1);
    check_decode("i13", 4'h1, 2'd0, 2'd3, 8'h01);
    step();
    mem_resp(8'h11, 0);
    check_decode("i11", 4'h1, 2'd0, 2'd1, 8'h02);

    // Stall held 3 cycles: outputs frozen, no new request
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_decode("stall", 4'h1, 2'd0, 2'd1, 8'h02);
      check("stall.req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    step();
    check("unstall.dvalid", 32'(decode_valid), 32'd0);
    check("unstall.req", 32'(imem_req), 32'd1);
    check("unstall.addr", 32'(imem_addr), 32'd3);

    // Walk PC to 5, then redirect while the fetch of 5 is outstanding
    mem_resp(8'h20, 0);
    step();
    mem_resp(8'h24, 0);
    step();
    check("pre_br.addr", 32'(imem_addr), 32'd5);
    branch_taken = 1'b1;
    branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    check("br.req", 32'(imem_req), 32'd1);
    check("br.addr", 32'(imem_addr), 32'h40);
    check("br.dvalid", 32'(decode_valid), 32'd0);
    mem_resp(8'hAA, 1);  // late response from the aborted fetch of 5
    check("late.dvalid", 32'(decode_valid), 32'd0);
    check("late.addr", 32'(imem_addr), 32'h40);
    mem_resp(8'h5C, 0);
    check_decode("i5c", 4'h5, 2'd3, 2'd0, 8'h40);

    // Redirect from ISSUE to 8'hFF, then the PC wraps
    branch_taken = 1'b1;
    branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    check("br_ff.addr", 32'(imem_addr), 32'hFF);
    mem_resp(8'h21, 0);
    check_decode("i21", 4'h2, 2'd0, 2'd1, 8'hFF);
    step();
    check("wrap.addr", 32'(imem_addr), 32'h00);

    // HALT: frozen, branch ignored
    mem_resp(8'hF0, 0);
    check_decode("halt", 4'hF, 2'd0, 2'd0, 8'h00);
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1;
    branch_target = 8'h40;
    step();
    step();
    branch_taken = 1'b0;
    check("halt_br.halted", 32'(halted), 32'd1);
    check("halt_br.req", 32'(imem_req), 32'd0);
    check("halt_br.addr", 32'(imem_addr), 32'd1);
    check("halt_br.dvalid", 32'(decode_valid), 32'd1);

    // Reset mid-FETCH with a response pending
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    mem_resp(8'h3A, 0);
    step();
    step();
    check("pre_rst.opcode", 32'(opcode), 32'd3);
    check("pre_rst.req", 32'(imem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst.req", 32'(imem_req), 32'd0);
    check("async_rst.opcode", 32'(opcode), 32'd0);
    check("async_rst.reg", 32'(reg_field), 32'd0);
    check("async_rst.imm", 32'(immediate), 32'd0);
    check("async_rst.addr", 32'(imem_addr), 32'd0);
    check("async_rst.dvalid", 32'(decode_valid), 32'd0);
    step();
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 8'h3A;
    step();
    imem_valid = 1'b0;
    check("stale.dvalid", 32'(decode_valid), 32'd0);
    check("stale.opcode", 32'(opcode), 32'd0);
    check("stale.req", 32'(imem_req), 32'd1);
    check("stale.addr", 32'(imem_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
